// File: rtl/math_div_pkg.sv
// math_div_pkg: shared constants for the radix-2 restoring divider.
// Holds the FSM state encoding, default operand widths and the
// iteration-counter width helper.
package math_div_pkg;

   localparam int DEF_DIVIDEND_WIDTH = 16;
   localparam int DEF_DIVISOR_WIDTH  = 16;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_CALC = 2'd1;
   localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = ST_IDLE,
      CALC = ST_CALC,
      DONE = ST_DONE
   } state_t;

   // The counter must hold the value DIVIDEND_WIDTH itself, hence +1.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/math_div_if.sv
// math_div_if: AXI-Stream style dividend, divisor and result channels of
// the divider. The divider side uses the slave modport, the requester
// (control FSM or bench) uses the master modport.
interface math_div_if
   import math_div_pkg::*;
#(
   parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
   parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH
);
   logic                      dividend_tvalid;
   logic [DIVIDEND_WIDTH-1:0] dividend_tdata;
   logic                      dividend_tready;
   logic                      divisor_tvalid;
   logic [DIVISOR_WIDTH-1:0]  divisor_tdata;
   logic                      divisor_tready;
   logic                      dout_tvalid;
   logic                      dout_tready;
   logic [DIVIDEND_WIDTH-1:0] quotient;
   logic [DIVISOR_WIDTH-1:0]  remainder;
   logic                      div_by_zero;

   modport slave (
      input  dividend_tvalid, dividend_tdata,
      output dividend_tready,
      input  divisor_tvalid, divisor_tdata,
      output divisor_tready,
      output dout_tvalid,
      input  dout_tready,
      output quotient, remainder, div_by_zero
   );

   modport master (
      output dividend_tvalid, dividend_tdata,
      input  dividend_tready,
      output divisor_tvalid, divisor_tdata,
      input  divisor_tready,
      input  dout_tvalid,
      output dout_tready,
      input  quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/math_div_in_chan.sv
// math_div_in_chan: one operand input channel of the divider.
// Generates TREADY, latches the operand on a handshake and remembers that
// the operand is present until the core clears it when starting a divide.
module math_div_in_chan #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_tvalid,
   input  logic [WIDTH-1:0] i_tdata,
   output logic             o_tready,
   input  logic             i_idle,
   input  logic             i_clear,
   output logic             o_got,
   output logic [WIDTH-1:0] o_data
);
   logic             r_flag;
   logic             r_tready;
   logic [WIDTH-1:0] r_data;
   logic             w_hs;
   logic             w_flag_next;

   assign w_hs        = i_tvalid && r_tready;
   // Operand is present if already held or arriving at this edge.
   assign o_got       = r_flag || w_hs;
   assign w_flag_next = i_clear ? 1'b0 : o_got;

   // Capture flag, registered ready and operand latch.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_flag   <= 1'b0;
         r_tready <= 1'b0;
         r_data   <= '0;
      end else begin
         r_flag   <= w_flag_next;
         // Ready only while idle and empty; never while the divide starts.
         r_tready <= i_idle && !w_flag_next && !i_clear;
         if (w_hs) begin
            r_data <= i_tdata;
         end
      end
   end

   assign o_tready = r_tready;
   assign o_data   = r_data;
endmodule

// File: rtl/math_div_core.sv
// math_div_core: iterative radix-2 restoring divider, one quotient bit per
// clock, with AXI-Stream operand inputs and a held result output.
// Optional macro MATH_DIV_SIGNED_EN selects two's complement operands
// (truncating division); without it operands are unsigned.
module math_div_core
   import math_div_pkg::*;
#(
   parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
   parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH
) (
   input logic      i_clk,
   input logic      i_rst,
   math_div_if.slave bus
);
   localparam int NW    = DIVIDEND_WIDTH;
   localparam int DW    = DIVISOR_WIDTH;
   localparam int CNT_W = cnt_width(NW);

   state_t          r_state;
   state_t          w_state_next;
   logic            w_idle;
   logic            w_start;
   logic            w_iter;
   logic            w_finish;
   logic            w_release;

   logic            w_dvd_got;
   logic            w_dvs_got;
   logic [NW-1:0]   w_dvd_data;
   logic [DW-1:0]   w_dvs_data;

   logic [CNT_W-1:0] r_cnt;
   logic [NW-1:0]   r_quo;
   logic [DW:0]     r_rem;

   logic            w_first;
   logic [NW-1:0]   w_dvd_mag;
   logic [DW-1:0]   w_dvs_mag;
   logic [NW-1:0]   w_q_src;
   logic [DW:0]     w_rem_src;
   logic [DW+1:0]   w_shift;
   logic [DW+1:0]   w_diff;
   logic            w_ge;

   logic            w_dvs_zero;
   logic [DW-1:0]   w_dvd_rs;
   logic [NW-1:0]   w_q_final;
   logic [DW-1:0]   w_r_final;

   logic            r_dout_tvalid;
   logic [NW-1:0]   r_quotient;
   logic [DW-1:0]   r_remainder;
   logic            r_dbz;

   assign w_idle = (r_state == IDLE);

   math_div_in_chan #(.WIDTH(NW)) u_dvd_chan (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_tvalid (bus.dividend_tvalid),
      .i_tdata  (bus.dividend_tdata),
      .o_tready (bus.dividend_tready),
      .i_idle   (w_idle),
      .i_clear  (w_start),
      .o_got    (w_dvd_got),
      .o_data   (w_dvd_data)
   );

   math_div_in_chan #(.WIDTH(DW)) u_dvs_chan (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_tvalid (bus.divisor_tvalid),
      .i_tdata  (bus.divisor_tdata),
      .o_tready (bus.divisor_tready),
      .i_idle   (w_idle),
      .i_clear  (w_start),
      .o_got    (w_dvs_got),
      .o_data   (w_dvs_data)
   );

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode and per-cycle action strobes.
   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_iter       = 1'b0;
      w_finish     = 1'b0;
      w_release    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_dvd_got && w_dvs_got) begin
               w_start      = 1'b1;
               w_state_next = CALC;
            end
         end
         CALC: begin
            if (r_cnt != '0) begin
               w_iter = 1'b1;
            end else begin
               w_finish     = 1'b1;
               w_state_next = DONE;
            end
         end
         DONE: begin
            if (bus.dout_tready) begin
               w_release    = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign w_dvs_zero = (w_dvs_data == '0);

   // Dividend resized to the remainder width for the divide-by-zero result.
   for (genvar gi = 0; gi < DW; gi++) begin : g_rs
      if (gi < NW) begin : g_bit
         assign w_dvd_rs[gi] = w_dvd_data[gi];
      end else begin : g_zero
         assign w_dvd_rs[gi] = 1'b0;
      end
   end

`ifdef MATH_DIV_SIGNED_EN
   logic w_dvd_neg;
   logic w_dvs_neg;
   assign w_dvd_neg = w_dvd_data[NW-1];
   assign w_dvs_neg = w_dvs_data[DW-1];
   // Magnitudes feed the unsigned iteration; most-negative maps to itself,
   // which read as unsigned is exactly its magnitude.
   assign w_dvd_mag = w_dvd_neg ? -w_dvd_data : w_dvd_data;
   assign w_dvs_mag = w_dvs_neg ? -w_dvs_data : w_dvs_data;
   // Truncation toward zero: quotient sign from the xor, remainder follows dividend.
   assign w_q_final = (w_dvd_neg ^ w_dvs_neg) ? -r_quo : r_quo;
   assign w_r_final = w_dvd_neg ? -r_rem[DW-1:0] : r_rem[DW-1:0];
`else
   assign w_dvd_mag = w_dvd_data;
   assign w_dvs_mag = w_dvs_data;
   assign w_q_final = r_quo;
   assign w_r_final = r_rem[DW-1:0];
`endif

   // The first iteration reads straight from the latched operand.
   assign w_first   = (r_cnt == CNT_W'(NW));
   assign w_q_src   = w_first ? w_dvd_mag : r_quo;
   assign w_rem_src = w_first ? '0 : r_rem;
   assign w_shift   = {w_rem_src, w_q_src[NW-1]};
   assign w_diff    = w_shift - {2'b00, w_dvs_mag};
   assign w_ge      = !w_diff[DW+1];

   // Iteration datapath: counter, quotient shift register, partial remainder.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
         r_quo <= '0;
         r_rem <= '0;
      end else begin
         if (w_start) begin
            r_cnt <= CNT_W'(NW);
         end
         if (w_iter) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_quo <= {w_q_src[NW-2:0], w_ge};
            r_rem <= w_ge ? w_diff[DW:0] : w_shift[DW:0];
         end
      end
   end

   // Result registers: loaded once per divide, held until the next one.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_dout_tvalid <= 1'b0;
         r_quotient    <= '0;
         r_remainder   <= '0;
         r_dbz         <= 1'b0;
      end else begin
         if (w_finish) begin
            r_dout_tvalid <= 1'b1;
            r_quotient    <= w_dvs_zero ? '1 : w_q_final;
            r_remainder   <= w_dvs_zero ? w_dvd_rs : w_r_final;
            r_dbz         <= w_dvs_zero;
         end
         if (w_release) begin
            r_dout_tvalid <= 1'b0;
         end
      end
   end

   assign bus.dout_tvalid = r_dout_tvalid;
   assign bus.quotient    = r_quotient;
   assign bus.remainder   = r_remainder;
   assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_math_div_core.sv
// tb_math_div_core: self-checking bench for math_div_core (16/16 widths).
// Directed vector table plus random operands checked against plain
// arithmetic; honours MATH_DIV_SIGNED_EN the same way as the design.
module tb_math_div_core;
   localparam int NW  = 16;
   localparam int DW  = 16;
   localparam int LAT = NW + 1;

   typedef struct {
      logic [NW-1:0] q;
      logic [DW-1:0] r;
      logic          z;
   } res_t;

   typedef struct {
      logic [NW-1:0] a;
      logic [DW-1:0] b;
      int            da;
      int            db;
      int            stall;
      res_t          exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   math_div_if #(.DIVIDEND_WIDTH(NW), .DIVISOR_WIDTH(DW)) bus ();

   math_div_core #(.DIVIDEND_WIDTH(NW), .DIVISOR_WIDTH(DW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: plain arithmetic on the operands.
   function automatic res_t ref_div(input logic [NW-1:0] a, input logic [DW-1:0] b);
      res_t res;
`ifdef MATH_DIV_SIGNED_EN
      int sa;
      int sb;
`endif
      if (b == '0) begin
         res.q = '1;
         res.r = a;
         res.z = 1'b1;
      end else begin
`ifdef MATH_DIV_SIGNED_EN
         sa = int'($signed(a));
         sb = int'($signed(b));
         res.q = NW'(sa / sb);
         res.r = DW'(sa % sb);
`else
         res.q = a / b;
         res.r = a % b;
`endif
         res.z = 1'b0;
      end
      return res;
   endfunction

   function automatic vec_t mk(input logic [NW-1:0] a, input logic [DW-1:0] b,
                               input int da, input int db, input int stall,
                               input logic [NW-1:0] q, input logic [DW-1:0] r, input logic z);
      vec_t v;
      v.a = a; v.b = b; v.da = da; v.db = db; v.stall = stall;
      v.exp.q = q; v.exp.r = r; v.exp.z = z;
      return v;
   endfunction

   // One complete divide; called and returns at a falling edge.
   task automatic run_op(input logic [NW-1:0] a, input logic [DW-1:0] b,
                         input int da, input int db, input int stall,
                         input res_t exp, input string tag);
      bit a_done = 0, b_done = 0, a_hs, b_hs, seen = 0, stable = 1;
      int a_edge = 0, b_edge = 0, hs_edge, t = 0;
      while (!(a_done && b_done) && t < 100) begin
         if (!a_done && t >= da) begin bus.dividend_tvalid = 1'b1; bus.dividend_tdata = a; end
         if (!b_done && t >= db) begin bus.divisor_tvalid = 1'b1; bus.divisor_tdata = b; end
         a_hs = bus.dividend_tvalid && bus.dividend_tready;
         b_hs = bus.divisor_tvalid && bus.divisor_tready;
         @(posedge clk);
         @(negedge clk);
         t++;
         if (a_hs) begin
            a_done = 1; a_edge = cyc;
            bus.dividend_tvalid = 1'b0; bus.dividend_tdata = NW'($urandom);
            check({tag, ".dvd_tready_drop"}, 32'(bus.dividend_tready), 0);
         end
         if (b_hs) begin
            b_done = 1; b_edge = cyc;
            bus.divisor_tvalid = 1'b0; bus.divisor_tdata = DW'($urandom);
            check({tag, ".dvs_tready_drop"}, 32'(bus.divisor_tready), 0);
         end
      end
      if (!(a_done && b_done)) begin
         check({tag, ".input_hs_timeout"}, 0, 1);
         bus.dividend_tvalid = 1'b0; bus.divisor_tvalid = 1'b0;
         return;
      end
      hs_edge = (a_edge > b_edge) ? a_edge : b_edge;
      for (int w = 0; w < 60 && !seen; w++) begin
         if (bus.dout_tvalid) seen = 1;
         else @(negedge clk);
      end
      check({tag, ".latency"}, seen ? 32'(cyc - hs_edge) : 32'hFFFF_FFFF, LAT);
      if (!seen) return;
      check({tag, ".quotient"}, 32'(bus.quotient), 32'(exp.q));
      check({tag, ".remainder"}, 32'(bus.remainder), 32'(exp.r));
      check({tag, ".div_by_zero"}, 32'(bus.div_by_zero), 32'(exp.z));
      check({tag, ".in_tready_done"}, {30'd0, bus.dividend_tready, bus.divisor_tready}, 0);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         if (!(bus.dout_tvalid && bus.quotient == exp.q && bus.remainder == exp.r &&
               bus.div_by_zero == exp.z && !bus.dividend_tready && !bus.divisor_tready))
            stable = 0;
      end
      if (stall > 0) check({tag, ".stall_hold"}, 32'(stable), 1);
      bus.dout_tready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.dout_tready = 1'b0;
      check({tag, ".tvalid_clear"}, 32'(bus.dout_tvalid), 0);
      check({tag, ".in_tready_lag"}, {30'd0, bus.dividend_tready, bus.divisor_tready}, 0);
      check({tag, ".q_held"}, 32'(bus.quotient), 32'(exp.q));
      @(negedge clk);
      check({tag, ".in_tready_back"}, {30'd0, bus.dividend_tready, bus.divisor_tready}, 3);
      $display("op %s a=%h b=%h q=%h r=%h z=%0d", tag, a, b, bus.quotient, bus.remainder, bus.div_by_zero);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [NW-1:0] ra;
      logic [DW-1:0] rb;
      bus.dividend_tvalid = 1'b0; bus.dividend_tdata = '0;
      bus.divisor_tvalid  = 1'b0; bus.divisor_tdata  = '0;
      bus.dout_tready     = 1'b0;

`ifdef MATH_DIV_SIGNED_EN
      vecs.push_back(mk(16'hFF9C, 16'd7,    0, 0, 0,  16'hFFF2, 16'hFFFE, 1'b0));
      vecs.push_back(mk(16'h8000, 16'hFFFF, 0, 0, 0,  16'h8000, 16'h0000, 1'b0));
      vecs.push_back(mk(16'h1234, 16'h0000, 0, 0, 0,  16'hFFFF, 16'h1234, 1'b1));
      vecs.push_back(mk(16'd1000, 16'd7,    0, 0, 0,  16'd142,  16'd6,    1'b0));
      vecs.push_back(mk(16'd7,    16'hFFFE, 5, 0, 0,  16'hFFFD, 16'd1,    1'b0));
      vecs.push_back(mk(16'hFFF9, 16'd2,    0, 3, 10, 16'hFFFD, 16'hFFFF, 1'b0));
      vecs.push_back(mk(16'd100,  16'd10,   1, 2, 0,  16'd10,   16'd0,    1'b0));
`else
      vecs.push_back(mk(16'd1000, 16'd7,    0, 0, 0,  16'd142,  16'd6,    1'b0));
      vecs.push_back(mk(16'hFFFF, 16'd3,    5, 0, 0,  16'h5555, 16'd0,    1'b0));
      vecs.push_back(mk(16'h1234, 16'h0000, 0, 0, 0,  16'hFFFF, 16'h1234, 1'b1));
      vecs.push_back(mk(16'd100,  16'd10,   0, 0, 10, 16'd10,   16'd0,    1'b0));
      vecs.push_back(mk(16'd0,    16'd5,    1, 2, 0,  16'd0,    16'd0,    1'b0));
      vecs.push_back(mk(16'd5,    16'hFFFF, 2, 0, 1,  16'd0,    16'd5,    1'b0));
      vecs.push_back(mk(16'hFFFF, 16'd1,    0, 3, 0,  16'hFFFF, 16'd0,    1'b0));
      vecs.push_back(mk(16'hFFFF, 16'hFFFF, 0, 0, 0,  16'd1,    16'd0,    1'b0));
`endif

      // Reset state.
      repeat (3) @(negedge clk);
      check("reset.tvalid", 32'(bus.dout_tvalid), 0);
      check("reset.in_tready", {30'd0, bus.dividend_tready, bus.divisor_tready}, 0);
      check("reset.outputs", {bus.quotient, bus.remainder}, 0);
      check("reset.dbz", 32'(bus.div_by_zero), 0);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].da, vecs[i].db, vecs[i].stall,
                vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Reset in the middle of CALC: everything drops at once, nothing emitted later.
      bus.dividend_tvalid = 1'b1; bus.dividend_tdata = 16'd500;
      bus.divisor_tvalid  = 1'b1; bus.divisor_tdata  = 16'd3;
      @(posedge clk);
      @(negedge clk);
      bus.dividend_tvalid = 1'b0; bus.divisor_tvalid = 1'b0;
      repeat (8) @(negedge clk);
      check("midcalc.tvalid_before", 32'(bus.dout_tvalid), 0);
      rst = 1'b1;
      #1;
      check("midcalc.rst_tvalid", 32'(bus.dout_tvalid), 0);
      check("midcalc.rst_in_tready", {30'd0, bus.dividend_tready, bus.divisor_tready}, 0);
      check("midcalc.rst_q", 32'(bus.quotient), 0);
      check("midcalc.rst_r", 32'(bus.remainder), 0);
      check("midcalc.rst_dbz", 32'(bus.div_by_zero), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op(16'd100, 16'd10, 0, 0, 0, ref_div(16'd100, 16'd10), "after_rst");

      // Reset while a result is waiting in DONE.
      run_op(16'd9, 16'd4, 0, 0, 0, ref_div(16'd9, 16'd4), "pre_done_rst");
      bus.dividend_tvalid = 1'b1; bus.dividend_tdata = 16'd77;
      bus.divisor_tvalid  = 1'b1; bus.divisor_tdata  = 16'd0;
      @(posedge clk);
      @(negedge clk);
      bus.dividend_tvalid = 1'b0; bus.divisor_tvalid = 1'b0;
      repeat (LAT + 2) @(negedge clk);
      check("done_rst.tvalid_before", 32'(bus.dout_tvalid), 1);
      rst = 1'b1;
      #1;
      check("done_rst.outputs", {14'd0, bus.dout_tvalid, bus.div_by_zero, bus.quotient}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Random operands against the reference.
      for (int k = 0; k < 40; k++) begin
         ra = NW'($urandom);
         if ($urandom_range(0, 7) == 0) rb = '0;
         else if ($urandom_range(0, 1) == 1) rb = DW'($urandom_range(1, 20));
         else rb = DW'($urandom);
         run_op(ra, rb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), ref_div(ra, rb), $sformatf("rnd%0d", k));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/math_div_core.md
Name: math_div_core

Overview:
- Iterative radix-2 restoring integer divider, one quotient bit per clock.
- AXI-Stream slave for the dividend and divisor channels; AXI-Stream master for the result (DOUT).
- It is the responder for the existing divide control FSM. That FSM raises DIVIDEND/DIVISOR TVALID, waits for DOUT TVALID, then pulses its load enable.

Parameters:
- DIVIDEND_WIDTH, 16, dividend and quotient width in bits (>=2).
- DIVISOR_WIDTH, 16, divisor and remainder width in bits (>=2).

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous active-high reset.
- iDIVIDEND_TVALID  input  1  dividend channel valid.
- iDIVIDEND_TDATA  input  DIVIDEND_WIDTH  dividend.
- oDIVIDEND_TREADY  output  1  dividend channel ready.
- iDIVISOR_TVALID  input  1  divisor channel valid.
- iDIVISOR_TDATA  input  DIVISOR_WIDTH  divisor.
- oDIVISOR_TREADY  output  1  divisor channel ready.
- oDOUT_TVALID  output  1  result valid.
- iDOUT_TREADY  input  1  result ready; tie high if unused.
- oQUOTIENT  output  DIVIDEND_WIDTH  quotient.
- oREMAINDER  output  DIVISOR_WIDTH  remainder.
- oDIV_BY_ZERO  output  1  divisor was zero.

Behaviour:
- Interface: one clock CLK; reset RST is asynchronous and active-high.
- Reset values: all outputs 0 (TREADYs, TVALID, QUOTIENT, REMAINDER, DIV_BY_ZERO). State is IDLE, capture flags cleared.
- States: IDLE, CALC, DONE; encoding comes from the package.
- IDLE:
  - Each channel's TREADY = (state==IDLE) && !captured_flag for that channel, registered.
  - A handshake (TVALID && TREADY) latches that channel's data and sets its flag. TREADY drops the following cycle.
  - Channels are independent: any order, same cycle, or many cycles apart.
  - When both flags are set, or become set at this edge: clear flags, load the iteration count with DIVIDEND_WIDTH, and go to CALC.
- CALC:
  - Each cycle, shift the partial remainder (DIVISOR_WIDTH+1 bits) left by one and bring in the next dividend MSB.
  - Trial-subtract the divisor. If non-negative, keep the difference and set quotient bit = 1; otherwise quotient bit = 0.
  - Repeat for exactly DIVIDEND_WIDTH cycles, then go to DONE.
- Latency: oDOUT_TVALID rises exactly DIVIDEND_WIDTH+1 edges after the edge completing the second input handshake (17 at default). Latency is fixed, including divide-by-zero.
- DONE:
  - oDOUT_TVALID = 1; QUOTIENT, REMAINDER and DIV_BY_ZERO are registered and held stable while TVALID && !TREADY.
  - On TVALID && TREADY: go to IDLE and clear TVALID at that edge. Both TREADYs are high the following cycle, so there is no overlap of a new capture with an unconsumed result.
- Divide by zero: QUOTIENT = all ones, REMAINDER = dividend truncated/zero-extended to DIVISOR_WIDTH, DIV_BY_ZERO = 1. DIV_BY_ZERO is 0 for every non-zero divisor.
- Data and flag outputs keep their last values after the handshake until the next DONE.
- RST asserted in any state (including mid-CALC or mid-DONE):
  - Immediately return all outputs to their reset values.
  - Discard partial results and capture flags.
  - No result is emitted for operands accepted before reset.
- TVALID dropping without a handshake is ignored; no data is captured.

Optional Feature:
- Macro MATH_DIV_SIGNED_EN.
- Defined: operands are two's complement.
  - At capture, store magnitudes and signs; the iteration is unchanged.
  - At the CALC→DONE edge: negate the quotient if signs differ; the remainder takes the dividend's sign (truncation toward zero).
  - Latency is unchanged.
  - Most-negative / -1 yields QUOTIENT = most-negative value (wraps), REMAINDER = 0.
  - Divide by zero behaves as in the unsigned case (all ones, dividend, flag).
- Undefined: operands are unsigned and no sign logic is synthesized.

Decomposition:
- Package math_div_pkg holds:
  - state encoding localparams IDLE/CALC/DONE and the state width;
  - the counter width function clog2(DIVIDEND_WIDTH+1);
  - default width constants.
- Sub-module math_div_in_chan, instantiated twice, one per channel:
  - TREADY generation, data latch, captured flag, clear input;
  - parameterised on data width.

Test Plan:
- Dividend 1000 and divisor 7 presented together → both TREADY accept in one cycle; TVALID 17 edges later with Q=142, R=6, DIV_BY_ZERO=0.
- Divisor 3 accepted, dividend 0xFFFF presented 5 cycles later → capture occurs only on the second handshake; Q=0x5555, R=0, latency measured from the dividend handshake.
- Dividend 0x1234, divisor 0 → Q=0xFFFF, R=0x1234, DIV_BY_ZERO=1 at the standard latency.
- iDOUT_TREADY held low 10 cycles after TVALID → outputs stable, both input TREADYs low; TREADY high for 1 cycle → TVALID low the next cycle, input TREADYs high the cycle after.
- RST pulsed at CALC iteration 8 → all outputs 0 asynchronously; after release, a new 100/10 yields Q=10, R=0 with no stale result.
- With MATH_DIV_SIGNED_EN: -100/7 → Q=0xFFF2 (-14), R=0xFFFE (-2); 0x8000/0xFFFF → Q=0x8000, R=0.
